// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop, LSB first, one bit per clock.
// Presents a registered {cout, sum} with a single-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             bit_s;
  logic             carry_next;

  always_comb begin
    bit_s      = sa_q[0] ^ sb_q[0] ^ c_q;
    carry_next = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    c_d     = c_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        ps_d  = {bit_s, ps_q[WIDTH-1:1]};
        c_d   = carry_next;
        cnt_d = cnt_q + CntW'(1);
        // Result registers move only here, so they never show a partial sum.
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          sum_d   = {bit_s, ps_q[WIDTH-1:1]};
          cout_d  = carry_next;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8: latency, busy width, done pulse,
// start-while-busy, asynchronous reset abort and back-to-back operation.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int cyc = 0;

  serial_adder #(
    .WIDTH(WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One complete addition from IDLE; leaves the FSM back in IDLE.
  task automatic do_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [8:0] exp);
    int lat;
    int bc;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bc    = busy ? 1 : 0;
    lat   = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bc++;
    end
    check({tag, ".lat"}, lat, WIDTH);
    check({tag, ".busy"}, bc, WIDTH);
    check({tag, ".res"}, {cout, sum}, exp);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, done, 1'b0);
  endtask

  initial begin
    int d0;
    int t_prev;
    int starts;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] pa [3];
    logic [7:0] pb [3];

    #2 rst_n = 1'b0;
    #1;
    check("rst.outs", {busy, done, cout, sum}, 11'h000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle.busy", busy, 1'b0);

    do_add("basic", 8'h05, 8'h03, 9'h008);
    do_add("ff01", 8'hFF, 8'h01, 9'h100);
    do_add("ffff", 8'hFF, 8'hFF, 9'h1FE);
    do_add("zero", 8'h00, 8'h00, 9'h000);

    // Second start three cycles into a run must be ignored; prior sum holds meanwhile.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sbusy.hold", {cout, sum}, 9'h000);
    check("sbusy.busy", busy, 1'b1);
    repeat (12) @(negedge clk);
    check("sbusy.res", {cout, sum}, 9'h030);
    check("sbusy.ndone", done_cnt - d0, 1);

    // Asynchronous reset between edges, four bit-cycles into a run.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst.outs", {busy, done, cout, sum}, 11'h000);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    check("arst.stale", done_cnt - d0, 0);
    do_add("arst.next", 8'h01, 8'h01, 9'h002);
    check("arst.ndone", done_cnt - d0, 1);

    // start held high: one result every WIDTH+2 cycles, each with its own operands.
    pa[0] = 8'h12; pb[0] = 8'h34;
    pa[1] = 8'hF0; pb[1] = 8'h20;
    pa[2] = 8'h81; pb[2] = 8'h7F;
    @(negedge clk);
    a = pa[0]; b = pb[0]; start = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      int w;
      w = 0;
      @(posedge clk);
      #1;
      while (!done && w < 20) begin
        @(posedge clk);
        #1;
        w++;
      end
      check($sformatf("b2b%0d.res", k), {cout, sum}, {1'b0, pa[k]} + {1'b0, pb[k]});
      if (k > 0) check($sformatf("b2b%0d.gap", k), cyc - t_prev, WIDTH + 2);
      t_prev = cyc;
      if (k < 2) begin
        a = pa[k+1]; b = pb[k+1];
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk);
    #1;

    // Random operands with random idle gaps.
    d0     = done_cnt;
    starts = 0;
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_add($sformatf("rnd%0d", i), ra, rb, {1'b0, ra} + {1'b0, rb});
      starts++;
    end
    @(negedge clk);
    check("rnd.ndone", done_cnt - d0, starts);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
